// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite write-side definitions: response codes, store size codes
// and the write-master FSM state type.
package axi_lite_pkg;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Store size codes; 2'd3 is reserved and always rejected
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWaitB,
      StResp
   } wr_state_e;

   // Anything other than OKAY is reported to the requester as an error
   function automatic logic is_err_resp(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/wr_lane_align.sv
// Byte-lane aligner for 32-bit stores: replicates right-justified data across
// lanes, builds the byte strobe and flags misaligned or reserved-size requests.
module wr_lane_align
   import axi_lite_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_data,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_misaligned
);

   // Lane replication and strobe selection by size
   always_comb begin
      o_wdata      = 32'h0;
      o_wstrb      = 4'h0;
      o_misaligned = 1'b0;
      unique case (i_size)
         SZ_B: begin
            o_wdata = {4{i_data[7:0]}};
            o_wstrb = 4'b0001 << i_addr_lo;
         end
         SZ_H: begin
            o_wdata      = {2{i_data[15:0]}};
            o_wstrb      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_misaligned = i_addr_lo[0];
         end
         SZ_W: begin
            o_wdata      = i_data;
            o_wstrb      = 4'b1111;
            o_misaligned = |i_addr_lo;
         end
         default: begin
            o_misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/axi_lite_wr_master.sv
// AXI4-Lite write initiator: accepts one store request, drives AW and W
// independently, waits for B and returns OK/error. One transaction in flight.
module axi_lite_wr_master
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clock,
   input  logic              i_reset,

   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_data,
   input  logic [1:0]        i_req_size,

   output logic              o_resp_valid,
   output logic              o_resp_err,
   input  logic              i_resp_ready,

   output logic [ADDR_W-1:0] o_axi_awaddr,
   output logic              o_axi_awvalid,
   input  logic              i_axi_awready,
   output logic [DATA_W-1:0] o_axi_wdata,
   output logic [3:0]        o_axi_wstrb,
   output logic              o_axi_wvalid,
   input  logic              i_axi_wready,
   input  logic [1:0]        i_axi_bresp,
   input  logic              i_axi_bvalid,
   output logic              o_axi_bready
);

   wr_state_e         state_q, state_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              resp_err_q, resp_err_d;

   logic [31:0]       lane_wdata;
   logic [3:0]        lane_wstrb;
   logic              lane_misaligned;

   wr_lane_align u_lane_align (
      .i_addr_lo    (i_req_addr[1:0]),
      .i_size       (i_req_size),
      .i_data       (i_req_data),
      .o_wdata      (lane_wdata),
      .o_wstrb      (lane_wstrb),
      .o_misaligned (lane_misaligned)
   );

   // Ready is gated by reset so nothing is accepted while held in reset
   assign o_req_ready   = (state_q == StIdle) && i_reset;
   assign o_axi_bready  = (state_q == StWaitB);
   assign o_resp_valid  = (state_q == StResp);
   assign o_resp_err    = resp_err_q;
   assign o_axi_awvalid = awvalid_q;
   assign o_axi_wvalid  = wvalid_q;
   assign o_axi_awaddr  = awaddr_q;
   assign o_axi_wdata   = wdata_q;
   assign o_axi_wstrb   = wstrb_q;

   // Next-state logic: capture, independent AW/W handshakes, B wait, completion
   always_comb begin
      state_d    = state_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      resp_err_d = resp_err_q;
      unique case (state_q)
         StIdle: begin
            if (i_req_valid && o_req_ready) begin
               if (lane_misaligned) begin
                  // Rejected locally; the bus never sees it
                  resp_err_d = 1'b1;
                  state_d    = StResp;
               end else begin
                  awvalid_d  = 1'b1;
                  wvalid_d   = 1'b1;
                  awaddr_d   = i_req_addr;
                  wdata_d    = lane_wdata;
                  wstrb_d    = lane_wstrb;
                  resp_err_d = 1'b0;
                  state_d    = StSend;
               end
            end
         end
         StSend: begin
            if (awvalid_q && i_axi_awready) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && i_axi_wready) begin
               wvalid_d = 1'b0;
            end
            // Both channels done, whether together or in different cycles
            if (!awvalid_d && !wvalid_d) begin
               state_d = StWaitB;
            end
         end
         StWaitB: begin
            if (i_axi_bvalid) begin
               resp_err_d = is_err_resp(i_axi_bresp);
               state_d    = StResp;
            end
         end
         StResp: begin
            if (i_resp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q    <= StIdle;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         resp_err_q <= resp_err_d;
      end
   end

endmodule

// File: doc/axi_lite_wr_master.md
Name: axi_lite_wr_master

Overview:
- AXI4-Lite write-channel initiator (AW/W/B only). Used by the core's store path to drive memory-mapped write-only slaves such as the simulation UART and the SoC peripherals.
- Takes a single store request (address, data, size), aligns the data to byte lanes, and runs the AW and W handshakes independently.
- Waits for the B response, then returns OK or error to the requester. One transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width of i_req_addr and o_axi_awaddr.
- DATA_W, 32, data width. Fixed at 32; the lane logic supports only 32.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-low (0 = reset).
- i_req_valid  in  1  store request valid.
- o_req_ready  out  1  block can accept a request.
- i_req_addr  in  ADDR_W  byte address.
- i_req_data  in  32  store data, right-justified.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- o_resp_valid  out  1  completion valid.
- o_resp_err  out  1  completion is an error (misaligned, reserved size, or non-OKAY bresp).
- i_resp_ready  in  1  requester accepts the completion.
- o_axi_awaddr  out  ADDR_W
- o_axi_awvalid  out  1
- i_axi_awready  in  1
- o_axi_wdata  out  32
- o_axi_wstrb  out  4
- o_axi_wvalid  out  1
- i_axi_wready  in  1
- i_axi_bresp  in  2
- i_axi_bvalid  in  1
- o_axi_bready  out  1

Behaviour:
- Reset (i_reset == 0 at a clock edge):
  - state = IDLE.
  - awvalid, wvalid, bready, resp_valid, resp_err all 0.
  - o_req_ready is 0 while i_reset == 0.
  - awaddr, wdata, wstrb are 0.
- Reset mid-operation aborts the transaction. Every valid is low the cycle after the reset edge and no completion is produced.
- States: IDLE, SEND, WAIT_B, RESP.
  - o_req_ready = (state == IDLE) && i_reset.
  - o_axi_bready = (state == WAIT_B).
  - o_resp_valid = (state == RESP).
- IDLE: on i_req_valid && o_req_ready, capture the request.
  - Illegal request: size 3, size 1 with addr[0] = 1, or size 2 with addr[1:0] != 0.
    - Go to RESP with resp_err = 1. No AXI activity.
  - Legal request: go to SEND.
    - Register awvalid = 1, wvalid = 1, awaddr = full address (low bits kept).
    - wdata lane replication:
      - byte: {4{d[7:0]}}
      - half: {2{d[15:0]}}
      - word: d
    - wstrb:
      - byte: 4'b0001 << addr[1:0]
      - half: addr[1] ? 4'b1100 : 4'b0011
      - word: 4'b1111
- SEND:
  - awvalid clears on the cycle after awvalid && awready. wvalid clears on the cycle after wvalid && wready. The two are tracked independently.
  - Neither valid may deassert, nor may address/data/strobe change, before its handshake.
  - When both handshakes are complete, go to WAIT_B. This includes both completing in the same cycle, and one completing in an earlier cycle than the other.
  - Handshakes are never repeated for one request.
- WAIT_B: bready = 1.
  - On i_axi_bvalid, latch resp_err = (bresp != 2'b00) and go to RESP.
  - An i_axi_bvalid that arrives before WAIT_B is ignored: bready is 0, so the slave holds it.
- RESP: hold resp_valid and resp_err stable until i_resp_ready, then go to IDLE. The next request can be accepted in the cycle after the completion handshake.
- Latency with always-ready slave and 1-cycle B (UART model):
  - Request accepted at edge T.
  - AW/W handshake in cycle T+1.
  - bvalid and bready in cycle T+2.
  - o_resp_valid in cycle T+3.
  - Minimum request-to-request period is 4 cycles.
- Misaligned or reserved request: o_resp_valid in cycle T+1.

Decomposition:
- Package axi_lite_pkg:
  - resp codes: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - size codes: SZ_B, SZ_H, SZ_W.
  - FSM state enum.
- Sub-module wr_lane_align: combinational (addr[1:0], size, data) -> (wdata, wstrb, misaligned). Reused later by the read-side load aligner.

Test Plan:
- Word store 0xDEADBEEF to 0x1000_0000, slave always ready, B OKAY next cycle -> awaddr 0x1000_0000, wdata 0xDEADBEEF, wstrb 4'hF, one AW and one W handshake, resp_valid at T+3 with err = 0.
- Byte store 0x41 to 0xA000_03F9 -> wdata 0x41414141, wstrb 4'b0010. Half store 0x1234 to 0x...02 -> wdata 0x12341234, wstrb 4'b1100.
- Staggered ready: awready high at T+1, wready high only at T+4 -> awvalid drops at T+2, wvalid stays high with stable data through T+4, bready first high at T+5.
- Misaligned half at 0x...01 and size 3 -> no awvalid/wvalid ever, resp_valid at T+1 with err = 1.
- bresp = SLVERR, with i_resp_ready held low for 3 cycles -> resp_valid and err = 1 held stable 3 cycles, o_req_ready low until the cycle after the resp handshake.
- i_reset driven low during SEND -> awvalid, wvalid, resp_valid all 0 next cycle. After release, a new word store completes normally.
